// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: flag bit positions
// and the result-stage occupancy encoding.
package alu_pkg;

  localparam int FLAG_C     = 0;
  localparam int FLAG_Z     = 1;
  localparam int FLAG_N     = 2;
  localparam int FLAG_V     = 3;
  localparam int FLAG_WIDTH = 4;

  // Encoded as {mainValid, skidValid}; 2'b01 is the illegal pattern.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational C/Z/N/V generation for an add-style result.
// Shared between the adder result stage and later logic units.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] result_i,
  input  logic                  carry_i,
  input  logic                  lhs_msb_i,
  input  logic                  rhs_msb_i,
  output logic [FLAG_WIDTH-1:0] flags_o
);

  logic res_msb;

  assign res_msb = result_i[DATA_WIDTH-1];

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_C] = carry_i;
    flags_o[FLAG_Z] = (result_i == '0);
    flags_o[FLAG_N] = res_msb;
    // Signed overflow: like-signed operands, result sign flipped.
    flags_o[FLAG_V] = (lhs_msb_i == rhs_msb_i) &&
                      (res_msb != lhs_msb_i);
  end

endmodule

// File: rtl/alu_result_stage.sv
// Adder result stage: flag generation, committed flags, 2-entry skid buffer.
// Optional perf counters enabled by defining ALU_RESULT_STAGE_PERF_EN.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  carryOut,
  input  logic                  lhsMsb,
  input  logic                  rhsMsb,
  input  logic                  flagsWrite,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic [FLAG_WIDTH-1:0] outFlags,
  output logic                  carryFlag,
  output logic [FLAG_WIDTH-1:0] flags,
`ifdef ALU_RESULT_STAGE_PERF_EN
  output logic [15:0]           acceptCount,
  output logic [15:0]           stallCount,
`endif
  input  logic                  busAssert,
  output tri   [DATA_WIDTH-1:0] mainBusOut
);

  stage_state_e          state_q;
  logic [DATA_WIDTH-1:0] main_data_q;
  logic [FLAG_WIDTH-1:0] main_flags_q;
  logic [DATA_WIDTH-1:0] skid_data_q;
  logic [FLAG_WIDTH-1:0] skid_flags_q;
  logic [FLAG_WIDTH-1:0] flags_q;

  logic [FLAG_WIDTH-1:0] in_flags;
  logic                  acc;
  logic                  dlv;

  alu_flag_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_flag_gen (
    .result_i (result),
    .carry_i  (carryOut),
    .lhs_msb_i(lhsMsb),
    .rhs_msb_i(rhsMsb),
    .flags_o  (in_flags)
  );

  // Handshake signals come straight from state bits, never from outReady.
  assign inReady  = ~state_q[0];
  assign outValid = state_q[1];
  assign acc      = inValid & inReady;
  assign dlv      = outValid & outReady;

  assign outData   = main_data_q;
  assign outFlags  = main_flags_q;
  assign flags     = flags_q;
  assign carryFlag = flags_q[FLAG_C];

  assign mainBusOut = (busAssert && outValid) ?
                      main_data_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      main_data_q  <= '0;
      main_flags_q <= '0;
      skid_data_q  <= '0;
      skid_flags_q <= '0;
      flags_q      <= '0;
    end else begin
      if (acc && flagsWrite) begin
        flags_q <= in_flags;
      end
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            main_data_q  <= result;
            main_flags_q <= in_flags;
            state_q      <= ONE;
          end
        end
        ONE: begin
          if (acc && dlv) begin
            main_data_q  <= result;
            main_flags_q <= in_flags;
          end else if (acc) begin
            skid_data_q  <= result;
            skid_flags_q <= in_flags;
            state_q      <= FULL;
          end else if (dlv) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (dlv) begin
            main_data_q  <= skid_data_q;
            main_flags_q <= skid_flags_q;
            skid_data_q  <= '0;
            skid_flags_q <= '0;
            state_q      <= ONE;
          end
        end
        default: begin
          // Skid-only occupancy is impossible; recover as from reset.
          state_q      <= EMPTY;
          main_data_q  <= '0;
          main_flags_q <= '0;
          skid_data_q  <= '0;
          skid_flags_q <= '0;
          flags_q      <= '0;
        end
      endcase
    end
  end

`ifdef ALU_RESULT_STAGE_PERF_EN
  logic [15:0] accept_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      accept_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (acc) begin
        accept_cnt_q <= accept_cnt_q + 16'd1;
      end
      if (inValid && !inReady) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign acceptCount = accept_cnt_q;
  assign stallCount  = stall_cnt_q;
`endif

endmodule
